instr_fetch_ctrl: RTL

Instruction fetch controller between the CPU's PC/INSTRUCTION port and a byte-wide, variable-latency instruction memory. Each 32-bit instruction is assembled from four sequential byte reads, big-endian: byte at the PC is the MSB. The result is held in a one-entry tagged instruction buffer. While a fetch is outstanding, the CPU is stalled through BUSYWAIT.

---
 rtl/instr_fetch_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl
//   Fetches 32-bit instructions for the CPU from a byte-wide, variable-latency
//   instruction memory. Four sequential byte reads are assembled big-endian
//   (the byte at the fetch base is the MSB) into a one-entry tagged buffer.
//   The CPU is stalled through busywait_o while a fetch is outstanding.
//
// Ports
//   clk             system clock, rising edge
//   rst_n           asynchronous reset, active low
//   pc_i            CPU program counter (byte address)
//   instruction_o   instruction for pc_i (0 on fault or empty buffer)
//   busywait_o      CPU stall request
//   fetch_fault_o   pc_i lies outside the instruction memory
//   invalidate_i    clear the instruction buffer (sampled on the clock edge)
//   mem_read_o      memory read request
//   mem_address_o   memory byte address
//   mem_readdata_i  memory read byte
//   mem_busywait_i  memory not ready; a byte completes on an edge where this is 0
module instr_fetch_ctrl #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           pc_i,
  output logic [31:0]           instruction_o,
  output logic                  busywait_o,
  output logic                  fetch_fault_o,
  input  logic                  invalidate_i,
  output logic                  mem_read_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  input  logic [7:0]            mem_readdata_i,
  input  logic                  mem_busywait_i
);

  localparam int TW = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    UPDATE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          buf_valid_q, buf_valid_d;
  logic [TW-1:0] buf_tag_q, buf_tag_d;
  logic [31:0]   buf_data_q, buf_data_d;
  logic [TW-1:0] base_q, base_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   asm_q, asm_d;
  logic          discard_q, discard_d;

  logic          out_of_range;
  logic [TW-1:0] pc_tag;
  logic          hit;

  // The two low PC bits select a byte inside the word and play no part here.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^pc_i[1:0];

  assign out_of_range = |pc_i[31:ADDR_WIDTH];
  assign pc_tag       = pc_i[ADDR_WIDTH-1:2];
  assign hit          = (state_q == IDLE) && buf_valid_q && (buf_tag_q == pc_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
      base_q      <= '0;
      cnt_q       <= '0;
      asm_q       <= '0;
      discard_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      discard_q   <= discard_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    discard_d   = discard_q;

    case (state_q)
      IDLE: begin
        if (invalidate_i) begin
          buf_valid_d = 1'b0;
        end
        if (!out_of_range && !hit) begin
          base_d    = pc_tag;
          cnt_d     = 2'd0;
          discard_d = 1'b0;
          state_d   = FETCH;
        end
      end

      FETCH: begin
        if (invalidate_i) begin
          discard_d = 1'b1;
        end
        if (!mem_busywait_i) begin
          // ~cnt equals 3-cnt: byte 0 of the word lands in the MSB lane.
          asm_d[{~cnt_q, 3'b000} +: 8] = mem_readdata_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = UPDATE;
          end
        end
      end

      UPDATE: begin
        buf_data_d  = asm_q;
        buf_tag_d   = base_q;
        // An invalidate arriving on this very edge also spoils the new entry.
        buf_valid_d = !(discard_q || invalidate_i);
        discard_d   = 1'b0;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs. Gating with rst_n keeps the stall asserted and the fault flag
  // quiet for as long as reset is held, independent of the clock.
  assign fetch_fault_o = rst_n && out_of_range;
  assign mem_read_o    = (state_q == FETCH);
  assign mem_address_o = mem_read_o ? {base_q, cnt_q} : '0;

  always_comb begin
    if (!rst_n) begin
      busywait_o = 1'b1;
    end else if (out_of_range) begin
      busywait_o = 1'b0;
    end else if (state_q != IDLE) begin
      busywait_o = 1'b1;
    end else begin
      busywait_o = !hit;
    end
  end

  assign instruction_o = (out_of_range || !buf_valid_q) ? 32'd0 : buf_data_q;

endmodule
